rx_serial_7n2: RTL and testbench

Asynchronous serial receiver for the 7N2 frame format: 1 start bit, 7 data bits LSB first, no parity, 2 stop bits, line idle high. It sits directly downstream of the 7N2 serial transmitter on the same 50 MHz clock domain. It recovers the ASCII character, flags framing errors, and holds the character for the consumer under a level handshake.

---
 rtl/rx_serial_7n2.sv | 198 +++++++++++++++++++
 tb/tb_rx_serial_7n2.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7n2.sv
// rtl/rx_serial_7n2.sv - 7N2 asynchronous serial receiver with framing check and level handshake
// Build macro: RX_SERIAL_7N2_STOP2_CHECK_EN (defined: a low second stop bit also flags erro)
// Ports:
//   clock              in   system clock, rising edge
//   reset              in   asynchronous reset, active-low
//   entrada_serial     in   serial line, asynchronous, idle high
//   recebe_dado        in   consumer acknowledge, clears tem_dado
//   dados_ascii[6:0]   out  last received character
//   pronto             out  one-cycle pulse per completed frame (good or bad)
//   tem_dado           out  an unacknowledged character is held
//   erro               out  framing error flag of the last frame
//   db_estado[3:0]     out  current FSM state code
//   db_tick            out  high for one cycle after each bit sample
//   db_entrada_serial  out  synchronized serial line

module rx_serial_7n2 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic       db_tick,
  output logic       db_entrada_serial
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  // The counter is cleared on state entry, so after k cycles it reads k-1.
  localparam logic [8:0] FULL_LAST = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] HALF_LAST = 9'(HALF_BIT - 1);

`ifdef RX_SERIAL_7N2_STOP2_CHECK_EN
  localparam logic STOP2_CHECK = 1'b1;
`else
  localparam logic STOP2_CHECK = 1'b0;
`endif

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    START        = 4'h1,
    DADOS        = 4'h2,
    STOP1        = 4'h3,
    STOP2        = 4'h4,
    ARMAZENA     = 4'h5,
    ESPERA_LINHA = 4'h6
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] shift_q, shift_d;
  logic       ferr_q, ferr_d;
  logic [6:0] dados_q, dados_d;
  logic       erro_q, erro_d;
  logic       pronto_q, pronto_d;
  logic       tem_q, tem_d;
  logic       tick_q, tick_d;

  logic rx_s;
  assign rx_s = sync2_q;

  always_comb begin
    sync1_d  = entrada_serial;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q + 9'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ferr_d   = ferr_q;
    dados_d  = dados_q;
    erro_d   = erro_q;
    pronto_d = 1'b0;
    tick_d   = 1'b0;
    tem_d    = recebe_dado ? 1'b0 : tem_q;

    case (state_q)
      INICIAL: begin
        cnt_d  = 9'd0;
        bit_d  = 3'd0;
        ferr_d = 1'b0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          tick_d = 1'b1;
          cnt_d  = 9'd0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx_s ? INICIAL : DADOS;
        end
      end

      DADOS: begin
        if (cnt_q == FULL_LAST) begin
          tick_d  = 1'b1;
          cnt_d   = 9'd0;
          shift_d = {rx_s, shift_q[6:1]};
          if (bit_q == 3'd6) begin
            state_d = STOP1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      STOP1: begin
        if (cnt_q == FULL_LAST) begin
          tick_d  = 1'b1;
          cnt_d   = 9'd0;
          ferr_d  = ~rx_s;
          state_d = STOP2;
        end
      end

      STOP2: begin
        if (cnt_q == FULL_LAST) begin
          tick_d = 1'b1;
          cnt_d  = 9'd0;
          // Outputs load on the way into ARMAZENA so they are valid during it.
          dados_d  = shift_q;
          erro_d   = ferr_q | (STOP2_CHECK & ~rx_s);
          pronto_d = 1'b1;
          tem_d    = 1'b1;
          state_d  = ARMAZENA;
        end
      end

      ARMAZENA: begin
        cnt_d = 9'd0;
        // An acknowledge landing in the pronto cycle must not drop the new character.
        tem_d = 1'b1;
        // After a bad stop bit the line may still be low; do not read it as a start.
        state_d = erro_q ? ESPERA_LINHA : INICIAL;
      end

      ESPERA_LINHA: begin
        cnt_d = 9'd0;
        if (rx_s) begin
          state_d = INICIAL;
        end
      end

      default: begin
        cnt_d   = 9'd0;
        state_d = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= INICIAL;
      cnt_q    <= 9'd0;
      bit_q    <= 3'd0;
      shift_q  <= 7'h00;
      ferr_q   <= 1'b0;
      dados_q  <= 7'h00;
      erro_q   <= 1'b0;
      pronto_q <= 1'b0;
      tem_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ferr_q   <= ferr_d;
      dados_q  <= dados_d;
      erro_q   <= erro_d;
      pronto_q <= pronto_d;
      tem_q    <= tem_d;
      tick_q   <= tick_d;
    end
  end

  assign dados_ascii       = dados_q;
  assign pronto            = pronto_q;
  assign tem_dado          = tem_q;
  assign erro              = erro_q;
  assign db_estado         = state_q;
  assign db_tick           = tick_q;
  assign db_entrada_serial = sync2_q;

endmodule

// File: tb/tb_rx_serial_7n2.sv
// tb/tb_rx_serial_7n2.sv - self-checking bench for rx_serial_7n2
`timescale 1ns/1ps

module tb_rx_serial_7n2;

  localparam int CPB = 434;

`ifdef RX_SERIAL_7N2_STOP2_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic       recebe_dado = 1'b0;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro;
  logic [3:0] db_estado;
  logic       db_tick;
  logic       db_entrada_serial;

  rx_serial_7n2 #(.CLKS_PER_BIT(CPB)) dut (
    .clock             (clock),
    .reset             (reset),
    .entrada_serial    (entrada_serial),
    .recebe_dado       (recebe_dado),
    .dados_ascii       (dados_ascii),
    .pronto            (pronto),
    .tem_dado          (tem_dado),
    .erro              (erro),
    .db_estado         (db_estado),
    .db_tick           (db_tick),
    .db_entrada_serial (db_entrada_serial)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Model: one entry per frame the line carries, outcome derived from the bit values.
  typedef struct {
    logic [6:0] d;
    logic       e;
    int         t0;
  } exp_t;

  exp_t       expq[$];
  logic [6:0] m_dados = 7'h00;
  logic       m_erro = 1'b0;
  int         ticks = 0;
  int         n_pronto = 0;
  bit         prev_pronto = 1'b0;
  bit         ack_arm = 1'b0;
  bit         ack_done = 1'b0;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Caller must be at a negedge; returns at the negedge where the next bit would start.
  task automatic send_frame(input logic [6:0] d, input bit s1, input bit s2,
                            input int extra_low, input bit expect_it);
    exp_t e;
    logic [9:0] bits;
    if (expect_it) begin
      e.d  = d;
      e.e  = !s1 || (CHK && !s2);
      e.t0 = cyc;
      expq.push_back(e);
      ticks = 0;
    end
    bits = {s2, s1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      entrada_serial = bits[i];
      repeat (CPB) @(negedge clock);
    end
    if (extra_low > 0) begin
      entrada_serial = 1'b0;
      repeat (extra_low * CPB) @(negedge clock);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin : cmp
    exp_t e;
    int   lat;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_dados     = 7'h00;
        m_erro      = 1'b0;
        prev_pronto = 1'b0;
      end else begin
        if (db_tick) ticks++;
        if (pronto) begin
          n_pronto++;
          chk("pronto_width", int'(prev_pronto), 0);
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pronto: got pronto at cycle %0d expected none", cyc);
          end else begin
            e       = expq.pop_front();
            m_dados = e.d;
            m_erro  = e.e;
            lat     = cyc - e.t0;
            total++;
            if (lat < 4126 || lat > 4128) begin
              bad++;
              $display("FAIL pronto_latency: got %0d expected 4127+-1", lat);
            end
            chk("tick_count", ticks, 10);
            chk("tem_dado_at_pronto", int'(tem_dado), 1);
          end
        end
        chk("dados_ascii", int'(dados_ascii), int'(m_dados));
        chk("erro", int'(erro), int'(m_erro));
        prev_pronto = pronto;
      end
    end
  end

  // Acknowledge in the same cycle as pronto when armed.
  initial begin : ack
    forever begin
      @(negedge clock);
      if (ack_arm && pronto) begin
        recebe_dado = 1'b1;
        ack_arm     = 1'b0;
        @(negedge clock);
        chk("tem_dado_set_wins", int'(tem_dado), 1);
        recebe_dado = 1'b0;
        ack_done    = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dados"}, int'(dados_ascii), 0);
    chk({tag, "_pronto"}, int'(pronto), 0);
    chk({tag, "_tem_dado"}, int'(tem_dado), 0);
    chk({tag, "_erro"}, int'(erro), 0);
    chk({tag, "_estado"}, int'(db_estado), 0);
    chk({tag, "_tick"}, int'(db_tick), 0);
    chk({tag, "_rx_s"}, int'(db_entrada_serial), 1);
  endtask

  initial begin : main
    int pre;
    repeat (20) @(negedge clock);
    chk_reset_values("rst");
    reset = 1'b1;
    wait_cycles(21);
    chk("idle_estado", int'(db_estado), 0);

    // Back-to-back loopback frames.
    send_frame(7'h35, 1'b1, 1'b1, 0, 1'b1);
    send_frame(7'h55, 1'b1, 1'b1, 0, 1'b1);
    wait_cycles(20);
    chk("b2b_dados", int'(dados_ascii), 'h55);
    chk("b2b_erro", int'(erro), 0);
    chk("b2b_n_pronto", n_pronto, 2);
    chk("b2b_tem_dado", int'(tem_dado), 1);

    // Glitch: 100 clocks low.
    entrada_serial = 1'b0;
    wait_cycles(10);
    chk("glitch_in_start", int'(db_estado), 1);
    wait_cycles(90);
    entrada_serial = 1'b1;
    wait_cycles(200);
    chk("glitch_back_idle", int'(db_estado), 0);
    chk("glitch_no_pronto", n_pronto, 2);

    // Framing error: STOP1 low, line held low two extra bit times.
    send_frame(7'h7E, 1'b0, 1'b0, 2, 1'b1);
    chk("ferr_espera_linha", int'(db_estado), 6);
    chk("ferr_erro", int'(erro), 1);
    chk("ferr_dados", int'(dados_ascii), 'h7E);
    entrada_serial = 1'b1;
    wait_cycles(5);
    chk("ferr_released", int'(db_estado), 0);
    wait_cycles(20);
    send_frame(7'h7F, 1'b1, 1'b1, 0, 1'b1);
    wait_cycles(20);
    chk("after_ferr_dados", int'(dados_ascii), 'h7F);
    chk("after_ferr_erro", int'(erro), 0);

    // Handshake.
    chk("tem_dado_held", int'(tem_dado), 1);
    ack_arm = 1'b1;
    send_frame(7'h41, 1'b1, 1'b1, 0, 1'b1);
    wait_cycles(20);
    chk("ack_happened", int'(ack_done), 1);
    chk("tem_dado_after_same_cycle_ack", int'(tem_dado), 1);
    chk("hs_dados", int'(dados_ascii), 'h41);
    recebe_dado = 1'b1;
    @(negedge clock);
    recebe_dado = 1'b0;
    chk("tem_dado_cleared", int'(tem_dado), 0);
    wait_cycles(10);

    // Reset during data bit 3 of a 7'h7F frame.
    pre = n_pronto;
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (3 * CPB + 200) @(negedge clock);
    chk("pre_reset_busy", int'(db_estado), 2);
    reset = 1'b0;
    #1;
    chk_reset_values("midrst");
    repeat (20) @(negedge clock);
    reset = 1'b1;
    wait_cycles(3000);
    chk("midrst_no_pronto", n_pronto, pre);
    chk("midrst_idle", int'(db_estado), 0);

    // STOP2 low: erro only when the STOP2 check is built in.
    send_frame(7'h2A, 1'b1, 1'b0, 0, 1'b1);
    entrada_serial = 1'b1;
    wait_cycles(600);
`ifdef RX_SERIAL_7N2_STOP2_CHECK_EN
    chk("stop2_low_erro", int'(erro), 1);
`else
    chk("stop2_low_erro", int'(erro), 0);
`endif
    chk("stop2_low_dados", int'(dados_ascii), 'h2A);
    chk("stop2_low_idle", int'(db_estado), 0);
    chk("all_frames_seen", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
